// File: rtl/hdc_deadlock_scheduler_if.sv
// -----------------------------------------------------------------------------
// hdc_deadlock_scheduler_if
// Report port between the deadlock scheduler and the bench deadlock reporter.
//
// Signals:
//   rpt_valid   report available (scheduler -> reporter)
//   rpt_ready   reporter accepts report (reporter -> scheduler)
//   rpt_ch_idx  index of the stalled channel being reported
//   rpt_mask    snapshot of all stalled channels at grant time
//   rpt_stamp   cycle counter captured at grant (only with DEADLOCK_CYCLE_STAMP_EN)
//
// Modports: master (scheduler side), slave (reporter side).
// Optional feature macro: DEADLOCK_CYCLE_STAMP_EN
// -----------------------------------------------------------------------------
interface hdc_deadlock_scheduler_if #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
`ifdef DEADLOCK_CYCLE_STAMP_EN
   ,
   parameter int CNT_W  = 16
`endif
);
   logic              rpt_valid;
   logic              rpt_ready;
   logic [CH_W-1:0]   rpt_ch_idx;
   logic [NUM_CH-1:0] rpt_mask;
`ifdef DEADLOCK_CYCLE_STAMP_EN
   logic [CNT_W-1:0]  rpt_stamp;

   modport master (output rpt_valid, rpt_ch_idx, rpt_mask, rpt_stamp, input rpt_ready);
   modport slave  (input rpt_valid, rpt_ch_idx, rpt_mask, rpt_stamp, output rpt_ready);
`else
   modport master (output rpt_valid, rpt_ch_idx, rpt_mask, input rpt_ready);
   modport slave  (input rpt_valid, rpt_ch_idx, rpt_mask, output rpt_ready);
`endif
endinterface

// File: rtl/hdc_deadlock_scheduler.sv
// -----------------------------------------------------------------------------
// hdc_deadlock_scheduler
// Watchdog and report scheduler for the hdc co-simulation deadlock monitors.
// Each channel is qualified as stalled after TIMEOUT consecutive blocked (and
// not idle) cycles; stalled channels are granted round-robin and reported once
// each on the rpt port. A sticky deadlock flag records any accepted report.
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous, active-low reset
//   enable           1 = scheduler active; 0 = back to IDLE after current report
//   clear            one-cycle pulse: clears deadlock flag and reported mask
//   axis_block_sigs  per-channel AXIS blocked flag
//   inst_idle_sigs   per-channel instance-idle flag (idle masks block)
//   rpt              report port (hdc_deadlock_scheduler_if.master)
//   deadlock         sticky: at least one report accepted since reset/clear
//   stalled          live per-channel stalled vector
//
// Optional feature macro: DEADLOCK_CYCLE_STAMP_EN (adds rpt.rpt_stamp)
// -----------------------------------------------------------------------------
module hdc_deadlock_scheduler #(
   parameter int NUM_CH  = 4,
   parameter int CH_W    = 2,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    clear,
   input  logic [NUM_CH-1:0]       axis_block_sigs,
   input  logic [NUM_CH-1:0]       inst_idle_sigs,
   hdc_deadlock_scheduler_if.master rpt,
   output logic                    deadlock,
   output logic [NUM_CH-1:0]       stalled
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_REPORT = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [CH_W-1:0]   last_q, last_d;
   logic [CH_W-1:0]   idx_q, idx_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [NUM_CH-1:0] reported_q, reported_d;
   logic              deadlock_q, deadlock_d;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] rot;
   logic [CH_W-1:0]   grant_idx;
   logic              found;
   logic              accept;
`ifdef DEADLOCK_CYCLE_STAMP_EN
   logic [CNT_W-1:0]  cyc_q;
   logic [CNT_W-1:0]  stamp_q, stamp_d;
`endif

   // Stalled is decoded from the registered counters only, so it never sees
   // the current-cycle block inputs.
   always_comb begin
      stalled = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         stalled[i] = (cnt_q[i] >= CNT_W'(TIMEOUT));
      end
   end

   assign eligible = stalled & ~reported_q;
   assign accept   = (state_q == ST_REPORT) && rpt.rpt_ready;

   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      idx_d      = idx_q;
      mask_d     = mask_q;
      reported_d = reported_q;
      deadlock_d = deadlock_q;
      found      = 1'b0;
      grant_idx  = '0;
      rot        = '0;
`ifdef DEADLOCK_CYCLE_STAMP_EN
      stamp_d    = stamp_q;
`endif

      // Persistence counters: count while blocked and not idle, saturate,
      // and restart from zero as soon as the condition lapses.
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = '0;
         if (axis_block_sigs[i] && !inst_idle_sigs[i]) begin
            cnt_d[i] = (&cnt_q[i]) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
         end
      end

      // Round-robin search starting just after the last granted channel.
      for (int k = 1; k <= NUM_CH; k++) begin
         rot = eligible >> ((int'(last_q) + k) % NUM_CH);
         if (!found && rot[0]) begin
            found     = 1'b1;
            grant_idx = CH_W'((int'(last_q) + k) % NUM_CH);
         end
      end

      // A channel whose counter is back at zero is no longer stalled, so its
      // reported bit is dropped even on the accepting edge; otherwise the
      // accept set beats a simultaneous clear pulse.
      for (int i = 0; i < NUM_CH; i++) begin
         if (cnt_q[i] == '0) begin
            reported_d[i] = 1'b0;
         end else if (accept && (idx_q == CH_W'(i))) begin
            reported_d[i] = 1'b1;
         end else if (clear) begin
            reported_d[i] = 1'b0;
         end
      end

      // A pending report always completes and sets the flag; clear only
      // drops the flag when no report is outstanding.
      if (accept) begin
         deadlock_d = 1'b1;
      end else if (clear && (state_q != ST_REPORT)) begin
         deadlock_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_SCAN;
         end
         ST_SCAN: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (found) begin
               idx_d   = grant_idx;
               mask_d  = stalled;
               last_d  = grant_idx;
               state_d = ST_REPORT;
`ifdef DEADLOCK_CYCLE_STAMP_EN
               stamp_d = cyc_q;
`endif
            end
         end
         ST_REPORT: begin
            // Held until the handshake: enable and channel changes are ignored.
            if (rpt.rpt_ready) state_d = ST_SCAN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         last_q     <= CH_W'(NUM_CH - 1);
         idx_q      <= '0;
         mask_q     <= '0;
         reported_q <= '0;
         deadlock_q <= 1'b0;
         // NOTE: the counter array is a handful of flops, not a RAM, and the
         // stall timing depends on it starting at zero, so it is reset.
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
`ifdef DEADLOCK_CYCLE_STAMP_EN
         cyc_q      <= '0;
         stamp_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         idx_q      <= idx_d;
         mask_q     <= mask_d;
         reported_q <= reported_d;
         deadlock_q <= deadlock_d;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
`ifdef DEADLOCK_CYCLE_STAMP_EN
         cyc_q      <= cyc_q + CNT_W'(1);
         stamp_q    <= stamp_d;
`endif
      end
   end

   assign rpt.rpt_valid  = (state_q == ST_REPORT);
   assign rpt.rpt_ch_idx = idx_q;
   assign rpt.rpt_mask   = mask_q;
`ifdef DEADLOCK_CYCLE_STAMP_EN
   assign rpt.rpt_stamp  = stamp_q;
`endif
   assign deadlock       = deadlock_q;

endmodule

// File: tb/tb_hdc_deadlock_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hdc_deadlock_scheduler
// Self-checking bench for hdc_deadlock_scheduler (TIMEOUT = 8). Expected
// reports are queued when stimulus is applied and compared on each handshake.
// -----------------------------------------------------------------------------
module tb_hdc_deadlock_scheduler;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;
   localparam int TO     = 8;
   localparam int CNT_W  = 16;

   typedef struct {
      logic [CH_W-1:0]   idx;
      logic [NUM_CH-1:0] mask;
   } exp_t;

   logic              clock = 1'b0;
   logic              reset;
   logic              enable;
   logic              clear;
   logic [NUM_CH-1:0] axis_block_sigs;
   logic [NUM_CH-1:0] inst_idle_sigs;
   logic              deadlock;
   logic [NUM_CH-1:0] stalled;

   int   vectors     = 0;
   int   miscompares = 0;
   exp_t exp_q[$];

`ifdef DEADLOCK_CYCLE_STAMP_EN
   hdc_deadlock_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) rpt_if ();
`else
   hdc_deadlock_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) rpt_if ();
`endif

   hdc_deadlock_scheduler #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W),
      .TIMEOUT(TO),
      .CNT_W  (CNT_W)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .clear          (clear),
      .axis_block_sigs(axis_block_sigs),
      .inst_idle_sigs (inst_idle_sigs),
      .rpt            (rpt_if.master),
      .deadlock       (deadlock),
      .stalled        (stalled)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [CH_W-1:0] idx, input logic [NUM_CH-1:0] mask);
      exp_t e;
      e.idx  = idx;
      e.mask = mask;
      exp_q.push_back(e);
   endtask

   // Synchronous reset for one edge; any pending report is discarded.
   task automatic do_reset(input string tag);
      reset           = 1'b0;
      enable          = 1'b0;
      clear           = 1'b0;
      axis_block_sigs = '0;
      inst_idle_sigs  = '0;
      rpt_if.rpt_ready = 1'b0;
      tick(1);
      exp_q.delete();
      check({tag, "_valid"},    rpt_if.rpt_valid,  0);
      check({tag, "_idx"},      rpt_if.rpt_ch_idx, 0);
      check({tag, "_mask"},     rpt_if.rpt_mask,   0);
      check({tag, "_deadlock"}, deadlock,          0);
      check({tag, "_stalled"},  stalled,           0);
`ifdef DEADLOCK_CYCLE_STAMP_EN
      check({tag, "_stamp"},    rpt_if.rpt_stamp,  0);
`endif
      reset = 1'b1;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n = 0;
      while (!rpt_if.rpt_valid && n < budget) begin
         tick(1);
         n++;
      end
      check(tag, rpt_if.rpt_valid, 1);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick(1);
         n++;
      end
      check(tag, exp_q.size(), 0);
   endtask

   task automatic count_valid(input string tag, input int cycles);
      int v = 0;
      for (int i = 0; i < cycles; i++) begin
         tick(1);
         if (rpt_if.rpt_valid) v++;
      end
      check(tag, v, 0);
   endtask

   // Handshake monitor: valid & ready at the negedge means the report is
   // accepted on the following rising edge.
   always @(negedge clock) begin
      if (reset === 1'b1 && rpt_if.rpt_valid === 1'b1 && rpt_if.rpt_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rpt", rpt_if.rpt_valid, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rpt_ch_idx", rpt_if.rpt_ch_idx, e.idx);
            check("rpt_mask",   rpt_if.rpt_mask,   e.mask);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rise[$];
      logic prev_v;

      // 1: single channel stall, timing and one-shot reporting
      do_reset("rst1");
      axis_block_sigs = 4'b0100;
      enable          = 1'b1;
      rpt_if.rpt_ready = 1'b1;
      push(2'd2, 4'b0100);
      tick(TO - 1);
      check("s1_stalled_early", stalled, 4'b0000);
      tick(1);
      check("s1_stalled_on",    stalled, 4'b0100);
      check("s1_valid_early",   rpt_if.rpt_valid, 0);
      tick(1);
      check("s1_valid",         rpt_if.rpt_valid, 1);
`ifdef DEADLOCK_CYCLE_STAMP_EN
      check("s1_stamp",         rpt_if.rpt_stamp, TO);
`endif
      tick(1);
      check("s1_deadlock",      deadlock, 1);
      check("s1_valid_drop",    rpt_if.rpt_valid, 0);
      count_valid("s1_no_repeat", 20);

      // 2: three simultaneous stalls, round-robin from last_grant = 3
      do_reset("rst2");
      axis_block_sigs = 4'b1011;
      enable          = 1'b1;
      rpt_if.rpt_ready = 1'b1;
      push(2'd0, 4'b1011);
      push(2'd1, 4'b1011);
      push(2'd3, 4'b1011);
      prev_v = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick(1);
         if (rpt_if.rpt_valid && !prev_v) rise.push_back(c);
         prev_v = rpt_if.rpt_valid;
      end
      check("s2_grants", rise.size(), 3);
      if (rise.size() == 3) begin
         check("s2_gap01", (rise[1] - rise[0]) >= 2, 1);
         check("s2_gap12", (rise[2] - rise[1]) >= 2, 1);
      end
      check("s2_drained", exp_q.size(), 0);

      // 3: backpressure with the channel unblocking mid-report
      do_reset("rst3");
      axis_block_sigs = 4'b0010;
      enable          = 1'b1;
      push(2'd1, 4'b0010);
      wait_valid("s3_valid", 20);
      axis_block_sigs = 4'b0000;
      for (int c = 0; c < 20; c++) begin
         tick(1);
         check("s3_hold_valid", rpt_if.rpt_valid,  1);
         check("s3_hold_idx",   rpt_if.rpt_ch_idx, 1);
         check("s3_hold_mask",  rpt_if.rpt_mask,   4'b0010);
      end
      check("s3_stalled_off", stalled, 4'b0000);
      rpt_if.rpt_ready = 1'b1;
      tick(1);
      check("s3_valid_drop", rpt_if.rpt_valid, 0);
      check("s3_deadlock",   deadlock, 1);
      check("s3_drained",    exp_q.size(), 0);

      // 4: release for one cycle re-arms the channel; idle masks block
      do_reset("rst4");
      axis_block_sigs = 4'b0001;
      enable          = 1'b1;
      rpt_if.rpt_ready = 1'b1;
      push(2'd0, 4'b0001);
      push(2'd0, 4'b0001);
      tick(TO);
      axis_block_sigs = 4'b0000;
      tick(1);
      axis_block_sigs = 4'b0001;
      tick(TO);
      wait_drain("s4_two_reports", 20);
      axis_block_sigs = 4'b0000;
      do_reset("rst4b");
      axis_block_sigs = 4'b0001;
      inst_idle_sigs  = 4'b0001;
      enable          = 1'b1;
      rpt_if.rpt_ready = 1'b1;
      count_valid("s4_idle_no_rpt", 30);
      check("s4_idle_stalled", stalled, 4'b0000);

      // 5: clear in SCAN drops deadlock; clear in REPORT loses to the accept
      do_reset("rst5");
      axis_block_sigs = 4'b0100;
      enable          = 1'b1;
      rpt_if.rpt_ready = 1'b1;
      push(2'd2, 4'b0100);
      wait_drain("s5_first", 30);
      check("s5_deadlock_set", deadlock, 1);
      rpt_if.rpt_ready = 1'b0;
      push(2'd2, 4'b0100);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check("s5_deadlock_clr", deadlock, 0);
      wait_valid("s5_rereport", 10);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check("s5_valid_kept", rpt_if.rpt_valid, 1);
      rpt_if.rpt_ready = 1'b1;
      tick(1);
      check("s5_deadlock_after", deadlock, 1);
      check("s5_valid_drop",     rpt_if.rpt_valid, 0);
      count_valid("s5_no_third", 15);

      // 6: reset in the middle of a report
      do_reset("rst6");
      axis_block_sigs = 4'b1000;
      enable          = 1'b1;
      push(2'd3, 4'b1000);
      wait_valid("s6_valid", 20);
      do_reset("s6_midrpt");
      axis_block_sigs = 4'b1000;
      enable          = 1'b1;
      push(2'd3, 4'b1000);
      tick(TO - 1);
      check("s6_restart_early", stalled, 4'b0000);
      tick(1);
      check("s6_restart_on",    stalled, 4'b1000);
      tick(1);
      check("s6_valid2", rpt_if.rpt_valid, 1);
`ifdef DEADLOCK_CYCLE_STAMP_EN
      check("s6_stamp",  rpt_if.rpt_stamp, TO);
`endif
      rpt_if.rpt_ready = 1'b1;
      wait_drain("s6_drain", 10);
      tick(1);
      check("s6_deadlock", deadlock, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
